cu_op_sequencer: RTL

//  Queued command sequencer for the 4-bit ALU/multiplier control unit (ops 00 add, 01 sub, 10 signed mul, 11 AND).

---
 rtl/cu_op_sequencer.sv | 233 +++++++++++++++++++++++
 1 files changed

// File: rtl/cu_op_sequencer.sv
// Queued command sequencer for the 4-bit ALU/multiplier control unit; optional per-command accumulator under CU_SEQ_ACC_EN.
// Latency: pop one edge after accept, capture SETTLE_CYCLES edges after pop; cmd_ready=0 when FIFO full, rsp_* held until rsp_ready.
module cu_op_sequencer #(
    parameter int QDEPTH        = 2,
    parameter int SETTLE_CYCLES = 1,
    parameter int CNT_W         = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [3:0]       cmd_a,
    input  logic [3:0]       cmd_b,
`ifdef CU_SEQ_ACC_EN
    input  logic             cmd_acc,
    output logic [7:0]       acc_value,
`endif
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [7:0]       rsp_res,
    output logic             rsp_zero,
    output logic             rsp_ovf,
    output logic             rsp_cout,
    output logic             cu_ctrl1,
    output logic             cu_ctrl0,
    output logic [3:0]       cu_a,
    output logic [3:0]       cu_b,
    input  logic [3:0]       cu_resl,
    input  logic [3:0]       cu_resh,
    input  logic             cu_zero,
    input  logic             cu_overflow,
    input  logic             cu_cout,
    output logic             busy,
    output logic [CNT_W-1:0] ovf_cnt
);

    localparam int AW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
    localparam int CW = $clog2(QDEPTH + 1);
    localparam int SW = $clog2(SETTLE_CYCLES + 1);
`ifdef CU_SEQ_ACC_EN
    localparam int EW = 11;
`else
    localparam int EW = 10;
`endif

    typedef enum logic [1:0] {IDLE, DRIVE, RESP} state_t;

    state_t           state_q, state_d;
    logic [EW-1:0]    mem_q [QDEPTH];
    logic [EW-1:0]    mem_d [QDEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic [SW-1:0]    cnt_q, cnt_d;
    logic             ctrl1_q, ctrl1_d, ctrl0_q, ctrl0_d;
    logic [3:0]       a_q, a_d, b_q, b_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic [7:0]       rsp_res_q, rsp_res_d;
    logic             rsp_zero_q, rsp_zero_d, rsp_ovf_q, rsp_ovf_d, rsp_cout_q, rsp_cout_d;
    logic [CNT_W-1:0] ovf_cnt_q, ovf_cnt_d;
    logic             empty, full, push, pop, capture;
    logic [EW-1:0]    wr_ent, rd_ent;
`ifdef CU_SEQ_ACC_EN
    logic             acc_flag_q, acc_flag_d;
    logic [7:0]       acc_q, acc_d;
`endif

    assign empty  = (count_q == '0);
    assign full   = (count_q == CW'(QDEPTH));
    assign push   = cmd_valid && !full;
    assign rd_ent = mem_q[rd_ptr_q];
`ifdef CU_SEQ_ACC_EN
    assign wr_ent = {cmd_acc, cmd_op, cmd_a, cmd_b};
`else
    assign wr_ent = {cmd_op, cmd_a, cmd_b};
`endif

    // Command FIFO; the registered count keeps cmd_ready free of any path from pop.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push) begin
            mem_d[wr_ptr_q] = wr_ent;
            wr_ptr_d        = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        count_d = count_q + CW'(push) - CW'(pop);
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        pop         = 1'b0;
        capture     = 1'b0;
        rsp_valid_d = rsp_valid_q;
        case (state_q)
            IDLE: begin
                if (!empty) begin
                    pop = 1'b1;
                end
            end
            DRIVE: begin
                cnt_d = cnt_q + SW'(1);
                if (cnt_q == SW'(SETTLE_CYCLES - 1)) begin
                    capture     = 1'b1;
                    rsp_valid_d = 1'b1;
                    state_d     = RESP;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    if (!empty) begin
                        pop = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        if (pop) begin
            cnt_d   = '0;
            state_d = DRIVE;
        end
    end

    // Operand registers hold their last value while idle; capture copies the datapath verbatim.
    always_comb begin
        ctrl1_d    = ctrl1_q;
        ctrl0_d    = ctrl0_q;
        a_d        = a_q;
        b_d        = b_q;
        rsp_res_d  = rsp_res_q;
        rsp_zero_d = rsp_zero_q;
        rsp_ovf_d  = rsp_ovf_q;
        rsp_cout_d = rsp_cout_q;
        ovf_cnt_d  = ovf_cnt_q;
        if (pop) begin
            {ctrl1_d, ctrl0_d, a_d, b_d} = rd_ent[9:0];
        end
        if (capture) begin
            rsp_res_d  = {cu_resh, cu_resl};
            rsp_zero_d = cu_zero;
            rsp_ovf_d  = cu_overflow;
            rsp_cout_d = cu_cout;
            // Only add/sub (Ctrl1=0) overflows are counted.
            if (!ctrl1_q && cu_overflow && (ovf_cnt_q != {CNT_W{1'b1}})) begin
                ovf_cnt_d = ovf_cnt_q + CNT_W'(1);
            end
        end
    end

`ifdef CU_SEQ_ACC_EN
    always_comb begin
        acc_flag_d = acc_flag_q;
        acc_d      = acc_q;
        if (pop) begin
            acc_flag_d = rd_ent[10];
        end
        if (capture && acc_flag_q) begin
            acc_d = acc_q + {cu_resh, cu_resl};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_flag_q <= 1'b0;
            acc_q      <= '0;
        end else begin
            acc_flag_q <= acc_flag_d;
            acc_q      <= acc_d;
        end
    end

    assign acc_value = acc_q;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            mem_q       <= '{default: '0};
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            cnt_q       <= '0;
            ctrl1_q     <= 1'b0;
            ctrl0_q     <= 1'b0;
            a_q         <= '0;
            b_q         <= '0;
            rsp_valid_q <= 1'b0;
            rsp_res_q   <= '0;
            rsp_zero_q  <= 1'b0;
            rsp_ovf_q   <= 1'b0;
            rsp_cout_q  <= 1'b0;
            ovf_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            mem_q       <= mem_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            cnt_q       <= cnt_d;
            ctrl1_q     <= ctrl1_d;
            ctrl0_q     <= ctrl0_d;
            a_q         <= a_d;
            b_q         <= b_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_res_q   <= rsp_res_d;
            rsp_zero_q  <= rsp_zero_d;
            rsp_ovf_q   <= rsp_ovf_d;
            rsp_cout_q  <= rsp_cout_d;
            ovf_cnt_q   <= ovf_cnt_d;
        end
    end

    assign cmd_ready = !full;
    assign rsp_valid = rsp_valid_q;
    assign rsp_res   = rsp_res_q;
    assign rsp_zero  = rsp_zero_q;
    assign rsp_ovf   = rsp_ovf_q;
    assign rsp_cout  = rsp_cout_q;
    assign cu_ctrl1  = ctrl1_q;
    assign cu_ctrl0  = ctrl0_q;
    assign cu_a      = a_q;
    assign cu_b      = b_q;
    assign busy      = (state_q != IDLE) || !empty;
    assign ovf_cnt   = ovf_cnt_q;

endmodule
